// File: rtl/usb_user_pkg.sv
// Shared address map and constants for the USB user-bus register bank.
package usb_user_pkg;

   localparam logic [15:0] REG_BASE = 16'h0000;
   localparam logic [15:0] STATUS_A = 16'h0010;
   localparam logic [15:0] ID_A     = 16'h0011;
   localparam logic [15:0] CNT_A    = 16'h0012;
   localparam logic [15:0] FLUSH_A  = 16'h0013;
   localparam logic [15:0] FIFO_LO  = 16'h0100;
   localparam logic [15:0] FIFO_HI  = 16'h01FF;

   localparam logic [31:0] ID_WORD  = 32'h4D50_4431;

   function automatic logic in_fifo_win(input logic [15:0] a);
      return (a >= FIFO_LO) && (a <= FIFO_HI);
   endfunction

endpackage

// File: rtl/usb_evt_fifo.sv
// Synchronous show-ahead event FIFO with sticky overflow and flush.
module usb_evt_fifo #(
   parameter int FIFO_AW = 9
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  logic [31:0]        push_data_i,
   input  logic               pop_i,
   input  logic               flush_i,
   output logic [31:0]        head_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [FIFO_AW:0]   count_o,
   output logic               overflow_o
);

   localparam int                 DEPTH   = 2 ** FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
   localparam logic [FIFO_AW:0]   CNT_ONE = 1;

   logic [31:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wp_q, rp_q;
   logic [FIFO_AW:0]   cnt_q, cnt_d;
   logic               ovf_q;
   logic               do_push, do_pop;

   assign full_o     = cnt_q[FIFO_AW];
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;
   assign overflow_o = ovf_q;
   assign head_o     = empty_o ? 32'h0 : mem_q[rp_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + CNT_ONE;
      else if (!do_push && do_pop)
         cnt_d = cnt_q - CNT_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (do_push) wp_q <= wp_q + PTR_ONE;
         if (do_pop)  rp_q <= rp_q + PTR_ONE;
         cnt_q <= cnt_d;
         if (push_i && full_o) ovf_q <= 1'b1;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i)
         mem_q[wp_q] <= push_data_i;
   end

endmodule

// File: rtl/usb_user_regbank.sv
// USER_* bus target: control registers, status/ID words and a pop-on-read event FIFO window.
module usb_user_regbank #(
   parameter int          NREG    = 16,
   parameter int          CE_BIT  = 0,
   parameter int          FIFO_AW = 9,
   parameter logic [31:0] ID_WORD = usb_user_pkg::ID_WORD
) (
   input  logic                CK50,
   input  logic                RESETb,
   input  logic [21:0]         USER_ADDR,
   inout  wire  [63:0]         USER_DATA,
   input  logic                USER_WEb,
   input  logic                USER_REb,
   input  logic                USER_OEb,
   input  logic [7:0]          USER_CEb,
   input  logic [31:0]         EVT_DATA,
   input  logic                EVT_WR,
   output logic                EVT_FULL,
   output logic [NREG*32-1:0]  REG_OUT,
   input  logic [31:0]         STATUS_IN
);

   import usb_user_pkg::*;

   logic               sel, wr_en, flush;
   logic [15:0]        addr;
   logic [31:0]        wdata, rdata;
   logic [31:0]        reg_q [NREG];
   logic [31:0]        reg_d [NREG];
   logic               oeb_s1_q, oeb_s2_q, oeb_s3_q, oeb_rise;
   logic               rd_sel_q;
   logic [15:0]        rd_addr_q;
   logic               pop;
   logic [31:0]        fifo_head;
   logic               fifo_empty, fifo_ovf;
   logic [FIFO_AW:0]   fifo_cnt;
   logic               unused_bits;

   assign sel   = !USER_CEb[CE_BIT];
   assign addr  = USER_ADDR[15:0];
   assign wdata = USER_DATA[31:0];
   assign wr_en = sel && !USER_WEb;
   assign flush = wr_en && (addr == FLUSH_A);

   assign unused_bits = ^{USER_ADDR[21:16], USER_DATA[63:32], fifo_empty};

   always_comb begin
      reg_d = reg_q;
      for (int i = 0; i < NREG; i++)
         if (wr_en && (addr == REG_BASE + 16'(i)))
            reg_d[i] = wdata;
   end

   always_ff @(posedge CK50) begin
      if (!RESETb) begin
         for (int i = 0; i < NREG; i++)
            reg_q[i] <= '0;
      end else begin
         reg_q <= reg_d;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_regout
      assign REG_OUT[32*g +: 32] = reg_q[g];
   end

   always_comb begin
      rdata = '0;
      case (addr)
         STATUS_A: rdata = STATUS_IN;
         ID_A:     rdata = ID_WORD;
         CNT_A:    rdata = {fifo_ovf, 15'b0, 16'(fifo_cnt)};
         default:  if (in_fifo_win(addr)) rdata = fifo_head;
      endcase
      for (int i = 0; i < NREG; i++)
         if (addr == REG_BASE + 16'(i))
            rdata = reg_q[i];
   end

   // Reset gates the driver combinationally so the bus is released at once.
   assign USER_DATA = (RESETb && sel && !USER_OEb) ? {32'b0, rdata} : 64'bz;

   // OEb is asynchronous; the pop waits for its synced rising edge, after the bridge has sampled.
   always_ff @(posedge CK50) begin
      if (!RESETb) begin
         oeb_s1_q  <= 1'b1;
         oeb_s2_q  <= 1'b1;
         oeb_s3_q  <= 1'b1;
         rd_sel_q  <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         oeb_s1_q <= USER_OEb;
         oeb_s2_q <= oeb_s1_q;
         oeb_s3_q <= oeb_s2_q;
         if (!USER_REb) begin
            rd_sel_q  <= sel;
            rd_addr_q <= addr;
         end else if (oeb_rise) begin
            rd_sel_q <= 1'b0;
         end
      end
   end

   assign oeb_rise = oeb_s2_q && !oeb_s3_q;
   assign pop      = oeb_rise && rd_sel_q && in_fifo_win(rd_addr_q);

   usb_evt_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk_i       (CK50),
      .rst_ni      (RESETb),
      .push_i      (EVT_WR),
      .push_data_i (EVT_DATA),
      .pop_i       (pop),
      .flush_i     (flush),
      .head_o      (fifo_head),
      .full_o      (EVT_FULL),
      .empty_o     (fifo_empty),
      .count_o     (fifo_cnt),
      .overflow_o  (fifo_ovf)
   );

endmodule
